// File: rtl/distortion_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | distortion_stage                                                          |
// | Ramped gain, selectable shaping curve and output saturation on a signed   |
// | valid/ready sample stream. Optional peak-hold: DIST_PEAK_HOLD_EN.         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module distortion_stage #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 12,
  parameter int RAMP_SHIFT = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic signed [DATA_W-1:0] gain_target,
  input  logic        [DATA_W-2:0] threshold,
  input  logic        [1:0]        mode,
  input  logic                     bypass,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
`ifdef DIST_PEAK_HOLD_EN
  input  logic                     peak_clr,
  output logic        [DATA_W-2:0] peak_abs,
`endif
  output logic                     clip_flag
);

  localparam int c_PW = 2 * DATA_W;
  localparam logic [1:0] c_MODE_HARD = 2'd0;
  localparam logic [1:0] c_MODE_SOFT = 2'd1;
  localparam logic [1:0] c_MODE_ASYM = 2'd2;
  localparam logic [1:0] c_MODE_PASS = 2'd3;
  localparam logic signed [DATA_W-1:0] c_UNITY =
    {{(DATA_W-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  logic w_en, w_in_xfer, w_out_xfer;

  // gain smoothing
  logic signed [DATA_W-1:0] r_gain;
  logic signed [DATA_W:0]   w_d, w_sh;
  logic signed [DATA_W-1:0] w_step;

  // stage registers
  logic                     r_v1, r_byp1;
  logic signed [c_PW-1:0]   r_p1;
  logic signed [DATA_W-1:0] r_in1;
  logic        [DATA_W-2:0] r_thr1;
  logic        [1:0]        r_mode1;
  logic                     r_v2, r_f2;
  logic signed [c_PW-1:0]   r_y2;
  logic                     r_v3, r_flag;
  logic signed [DATA_W-1:0] r_out;

  logic signed [c_PW-1:0]   w_prod, w_p1;
  logic signed [c_PW-1:0]   w_t, w_thalf, w_abs, w_knee, w_y;
  logic                     w_f;
  logic        [DATA_W:0]   w_hi;
  logic                     w_ovf;
  logic signed [DATA_W-1:0] w_sat;

  assign w_en       = !r_v3 || out_ready;
  assign in_ready   = w_en;
  assign w_in_xfer  = in_valid && w_en;
  assign w_out_xfer = r_v3 && out_ready;
  assign out_valid  = r_v3;
  assign out_sample = r_out;
  assign clip_flag  = r_flag;

  // A step that shifts to zero still moves one LSB, so the ramp always lands exactly.
  assign w_d    = {gain_target[DATA_W-1], gain_target} - {r_gain[DATA_W-1], r_gain};
  assign w_sh   = w_d >>> RAMP_SHIFT;
  assign w_step = (w_sh == '0 && w_d != '0)
                ? (w_d[DATA_W] ? {DATA_W{1'b1}} : {{(DATA_W-1){1'b0}}, 1'b1})
                : w_sh[DATA_W-1:0];

  assign w_prod = c_PW'(in_sample) * c_PW'(r_gain);
  assign w_p1   = w_prod >>> FRAC_BITS;

  assign w_t     = $signed({{(DATA_W+1){1'b0}}, r_thr1});
  assign w_thalf = w_t >>> 1;
  assign w_abs   = r_p1[c_PW-1] ? -r_p1 : r_p1;
  assign w_knee  = w_t + ((w_abs - w_t) >>> 2);

  always_comb begin
    w_y = r_p1;
    w_f = 1'b0;
    if (r_byp1) begin
      w_y = c_PW'(r_in1);
    end else begin
      case (r_mode1)
        c_MODE_HARD: begin
          if (r_p1 > w_t) begin
            w_y = w_t;
            w_f = 1'b1;
          end else if (r_p1 < -w_t) begin
            w_y = -w_t;
            w_f = 1'b1;
          end
        end
        c_MODE_SOFT: begin
          if (w_abs > w_t) begin
            w_y = r_p1[c_PW-1] ? -w_knee : w_knee;
            w_f = 1'b1;
          end
        end
        c_MODE_ASYM: begin
          if (r_p1 > w_t) begin
            w_y = w_t;
            w_f = 1'b1;
          end else if (r_p1 < -w_thalf) begin
            w_y = -w_thalf;
            w_f = 1'b1;
          end
        end
        c_MODE_PASS: w_y = r_p1;
        default:     w_y = r_p1;
      endcase
    end
  end

  // Out of range whenever the bits above the output sign are not all sign copies.
  assign w_hi  = r_y2[c_PW-1:DATA_W-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));
  assign w_sat = w_ovf ? (r_y2[c_PW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}})
                       : r_y2[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gain <= c_UNITY;
    end else if (w_in_xfer) begin
      r_gain <= r_gain + w_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_p1    <= '0;
      r_in1   <= '0;
      r_thr1  <= '0;
      r_mode1 <= '0;
      r_byp1  <= 1'b0;
      r_v2    <= 1'b0;
      r_y2    <= '0;
      r_f2    <= 1'b0;
      r_v3    <= 1'b0;
      r_out   <= '0;
      r_flag  <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_p1    <= w_p1;
        r_in1   <= in_sample;
        r_thr1  <= threshold;
        r_mode1 <= mode;
        r_byp1  <= bypass;
      end
      if (r_v1) begin
        r_y2 <= w_y;
        r_f2 <= w_f;
      end
      if (r_v2) begin
        r_out  <= w_sat;
        r_flag <= r_f2 || w_ovf;
      end
    end
  end

`ifdef DIST_PEAK_HOLD_EN
  logic [DATA_W-2:0]        r_peak;
  logic signed [DATA_W-1:0] w_neg;
  logic [DATA_W-2:0]        w_oabs;

  // Negating the most-negative code wraps to itself; report it as full scale.
  assign w_neg    = -r_out;
  assign w_oabs   = r_out[DATA_W-1] ? (w_neg[DATA_W-1] ? {(DATA_W-1){1'b1}} : w_neg[DATA_W-2:0])
                                    : r_out[DATA_W-2:0];
  assign peak_abs = r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= w_out_xfer ? w_oabs : '0;
    end else if (w_out_xfer && (w_oabs > r_peak)) begin
      r_peak <= w_oabs;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_distortion_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_distortion_stage                                                       |
// | Directed and random stimulus against an arithmetic reference model.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_distortion_stage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_sample;
  logic signed [15:0] gain_target;
  logic        [14:0] threshold;
  logic        [1:0]  mode;
  logic               bypass;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sample;
  logic               clip_flag;

  always #5 clk = ~clk;

  distortion_stage #(.DATA_W(16), .FRAC_BITS(12), .RAMP_SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .gain_target(gain_target), .threshold(threshold), .mode(mode), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .clip_flag(clip_flag)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  g_model;
  bit  chk_lat;
  int  exp_s[$];
  int  exp_f[$];
  int  exp_c[$];
  int  got_s[$];
  int  got_f[$];

  task automatic chk(string tag, longint obs, longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint fdiv(longint a, longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int gs(int i);
    if (i < got_s.size()) return got_s[i];
    return 99999;
  endfunction

  function automatic int gf(int i);
    if (i < got_f.size()) return got_f[i];
    return 9;
  endfunction

  // Reference: scale, shape, saturate, then move the gain toward its target.
  task automatic model_push(int s);
    longint x, y, t, d, st;
    int     f;
    t = longint'(threshold);
    x = fdiv(longint'(s) * longint'(g_model), 4096);
    y = x;
    if (bypass) begin
      y = s;
    end else begin
      case (mode)
        2'd0: y = (x > t) ? t : ((x < -t) ? -t : x);
        2'd1: y = (x > t) ? t + (x - t) / 4 : ((x < -t) ? -(t + (-x - t) / 4) : x);
        2'd2: y = (x > t) ? t : ((x < -(t / 2)) ? -(t / 2) : x);
        default: y = x;
      endcase
    end
    f = (!bypass && y != x) ? 1 : 0;
    if (y > 32767) begin y = 32767; f = 1; end
    if (y < -32768) begin y = -32768; f = 1; end
    exp_s.push_back(int'(y));
    exp_f.push_back(f);
    exp_c.push_back(cyc);
    d  = longint'(gain_target) - longint'(g_model);
    st = fdiv(d, 64);
    if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
    g_model = g_model + int'(st);
  endtask

  task automatic tick(output bit xin);
    bit xo;
    #1;
    xo  = out_valid && out_ready;
    xin = in_valid && in_ready;
    if (xo) begin
      chk("sb_nonempty", longint'(exp_s.size() > 0), 1);
      if (exp_s.size() > 0) begin
        chk("sb_sample", out_sample, exp_s.pop_front());
        chk("sb_flag", clip_flag, exp_f.pop_front());
        if (chk_lat) chk("latency", cyc - exp_c[0], 3);
        void'(exp_c.pop_front());
      end
      got_s.push_back(int'(out_sample));
      got_f.push_back(int'(clip_flag));
    end
    if (xin) model_push(int'(in_sample));
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(int s);
    bit x;
    int n;
    in_valid  = 1'b1;
    in_sample = 16'(s);
    n = 0;
    do begin
      tick(x);
      n++;
    end while (!x && n < 50);
    chk("send_accept", longint'(x), 1);
  endtask

  task automatic drain();
    bit x;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_s.size() > 0 && n < 50) begin
      tick(x);
      n++;
    end
    chk("drain_empty", exp_s.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    int k, n, held;
    int bp_vals[5];
    bp_vals = '{100, 200, 300, 400, 500};

    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; gain_target = 16'sd4096;
    threshold = 15'd2048; mode = 2'd0; bypass = 1'b0; out_ready = 1'b1;
    g_model = 4096; chk_lat = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_clip_flag", clip_flag, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // hard clip, back to back
    chk_lat = 1'b1;
    send(3000); send(-1000); send(2048);
    drain();
    chk("hard_out0", gs(0), 2048);  chk("hard_flag0", gf(0), 1);
    chk("hard_out1", gs(1), -1000); chk("hard_flag1", gf(1), 0);
    chk("hard_out2", gs(2), 2048);  chk("hard_flag2", gf(2), 0);

    // soft knee and asymmetric
    got_s.delete(); got_f.delete();
    mode = 2'd1; send(4048);
    mode = 2'd2; send(-3000);
    drain();
    chk("soft_out", gs(0), 2548);  chk("soft_flag", gf(0), 1);
    chk("asym_out", gs(1), -1024); chk("asym_flag", gf(1), 1);

    // T=0 hard clip
    got_s.delete(); got_f.delete();
    mode = 2'd0; threshold = 15'd0; send(1234);
    drain();
    chk("t0_out", gs(0), 0); chk("t0_flag", gf(0), 1);
    threshold = 15'd2048;

    // backpressure
    got_s.delete(); got_f.delete();
    chk_lat = 1'b0; mode = 2'd3; out_ready = 1'b0; in_valid = 1'b1; k = 0;
    for (int i = 0; i < 8; i++) begin
      in_sample = 16'(bp_vals[k < 5 ? k : 4]);
      tick(x);
      if (x) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    held = int'(out_sample);
    for (int i = 0; i < 3; i++) begin
      tick(x);
      if (x) k++;
      chk("bp_hold", out_sample, held);
    end
    out_ready = 1'b1; n = 0;
    while (k < 5 && n < 50) begin
      in_sample = 16'(bp_vals[k]);
      tick(x);
      if (x) k++;
      n++;
    end
    drain();
    chk("bp_count", got_s.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_order", gs(i), bp_vals[i]);

    // gain ramp toward 2.0
    got_s.delete(); got_f.delete();
    chk_lat = 1'b1; gain_target = 16'sd8192;
    n = 0;
    while (g_model != 8192 && n < 2000) begin
      send(1000);
      n++;
    end
    drain();
    chk("ramp_out0", gs(0), 1000);
    chk("ramp_out1", gs(1), 1015);
    chk("ramp_out2", gs(2), 1031);
    got_s.delete(); got_f.delete();
    repeat (4) send(1000);
    drain();
    for (int i = 0; i < 4; i++) chk("ramp_settled", gs(i), 2000);

    // saturation with negative gain, then bypass
    gain_target = -16'sd4096;
    n = 0;
    while (g_model != -4096 && n < 3000) begin
      send(0);
      n++;
    end
    drain();
    got_s.delete(); got_f.delete();
    send(-32768);
    bypass = 1'b1; send(-32768); bypass = 1'b0;
    drain();
    chk("sat_out", gs(0), 32767);   chk("sat_flag", gf(0), 1);
    chk("byp_out", gs(1), -32768);  chk("byp_flag", gf(1), 0);

    // reset with samples in flight
    gain_target = 16'sd8192;
    send(1000); send(1000);
    in_valid = 1'b0;
    tick(x);
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    exp_s.delete(); exp_f.delete(); exp_c.delete();
    g_model = 4096;
    @(negedge clk);
    rst_n = 1'b1;
    got_s.delete(); got_f.delete();
    send(1000); send(1000);
    drain();
    chk("rst_gain0", gs(0), 1000);
    chk("rst_gain1", gs(1), 1015);

    // random traffic with random backpressure
    chk_lat = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int gt;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sample = 16'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        gt = int'($urandom_range(0, 16384)) - 8192;
        gain_target = 16'(gt);
      end
      mode      = 2'($urandom);
      bypass    = ($urandom_range(0, 7) == 0);
      threshold = 15'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(x);
    end
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
